// File: rtl/sm_cpz_vic.sv
// sm_cpz_vic: CP0-style exception/interrupt controller with Count/Compare timer.
// Vectored interrupt addressing is built only when SM_CPZ_VECTORED_IRQ_EN is defined.
module sm_cpz_vic #(
    parameter int          IRQ_NUM     = 6,
    parameter logic [31:0] EBASE_RST   = 32'h0000_0000,
    parameter int          VEC_SPACING = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [31:0]        cp0_PC,
    output logic [31:0]        cp0_EPC,
    output logic [31:0]        cp0_ExcHandler,
    output logic               cp0_ExcRequest,
    output logic               cp0_ExcIsSync,
    input  logic               cp0_ExcEret,
    input  logic [4:0]         cp0_regNum,
    input  logic [2:0]         cp0_regSel,
    output logic [31:0]        cp0_regRD,
    input  logic [31:0]        cp0_regWD,
    input  logic               cp0_regWE,
    input  logic [IRQ_NUM-1:0] cp0_ExcIP,
    input  logic               cp0_ExcRI,
    input  logic               cp0_ExcOv
);

    localparam logic [4:0] EXC_INT = 5'h00;
    localparam logic [4:0] EXC_RI  = 5'h0a;
    localparam logic [4:0] EXC_OV  = 5'h0c;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_REQ   = 2'd1,
        ST_INEXC = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [IRQ_NUM-1:0]  ip_meta_q, ip_sync_q;
    logic [31:0]         count_q, count_d;
    logic [31:0]         compare_q, compare_d;
    logic                ti_q, ti_d;
    logic [7:0]          im_q, im_d;
    logic                exl_q, exl_d;
    logic                ie_q, ie_d;
    logic [1:0]          sw_ip_q, sw_ip_d;
    logic                dc_q, dc_d;
    logic                iv_q, iv_d;
    logic [4:0]          exccode_q, exccode_d;
    logic [31:0]         epc_q, epc_d;
    logic [17:0]         ebase_q, ebase_d;

    logic                we_count_s, we_compare_s, we_status_s;
    logic                we_cause_s, we_epc_s, we_ebase_s;
    logic [5:0]          hw_ext_s;
    logic [7:0]          ip_s, pend_s;
    logic                int_cond_s, sync_cond_s, take_s;
    logic [31:0]         ebase_addr_s;

    assign we_count_s   = cp0_regWE && (cp0_regNum == 5'd9)  && (cp0_regSel == 3'd0);
    assign we_compare_s = cp0_regWE && (cp0_regNum == 5'd11) && (cp0_regSel == 3'd0);
    assign we_status_s  = cp0_regWE && (cp0_regNum == 5'd12) && (cp0_regSel == 3'd0);
    assign we_cause_s   = cp0_regWE && (cp0_regNum == 5'd13) && (cp0_regSel == 3'd0);
    assign we_epc_s     = cp0_regWE && (cp0_regNum == 5'd14) && (cp0_regSel == 3'd0);
    assign we_ebase_s   = cp0_regWE && (cp0_regNum == 5'd15) && (cp0_regSel == 3'd1);

    // Hardware lines widened to the full IP[7:2] field; unused lines read 0
    always_comb begin
        hw_ext_s = 6'b00_0000;
        for (int i = 0; i < IRQ_NUM; i++) begin
            hw_ext_s[i] = ip_sync_q[i];
        end
    end

    assign ip_s         = {hw_ext_s[5] | ti_q, hw_ext_s[4:0], sw_ip_q};
    assign pend_s       = ip_s & im_q;
    assign int_cond_s   = ie_q & ~exl_q & (|pend_s);
    assign sync_cond_s  = (cp0_ExcRI | cp0_ExcOv) & ~exl_q;
    assign take_s       = (state_q == ST_IDLE) && (int_cond_s || sync_cond_s);
    assign ebase_addr_s = {2'b00, ebase_q, 12'h000};

`ifdef SM_CPZ_VECTORED_IRQ_EN
    localparam int VEC_SHIFT = $clog2(VEC_SPACING);

    logic [2:0] vec_idx_q, vec_idx_d;

    function automatic logic [2:0] vec_index(input logic [7:0] pend);
        logic [2:0] idx;
        idx = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if (pend[i]) idx = 3'(i);
            else idx = idx;
        end
        return idx;
    endfunction

    // Vector index captured when the exception is taken
    always_comb begin
        if (take_s) vec_idx_d = vec_index(pend_s);
        else vec_idx_d = vec_idx_q;
    end

    // Vector index register
    always_ff @(posedge clk) begin
        if (rst) vec_idx_q <= 3'd0;
        else vec_idx_q <= vec_idx_d;
    end

    // Handler address: vectored only for interrupts with IV set
    always_comb begin
        if (iv_q && (exccode_q == EXC_INT))
            cp0_ExcHandler = ebase_addr_s + 32'h0000_0200 + ({29'd0, vec_idx_q} << VEC_SHIFT);
        else
            cp0_ExcHandler = ebase_addr_s + 32'h0000_0180;
    end
`else
    assign cp0_ExcHandler = ebase_addr_s + 32'h0000_0180;
`endif

    // Two-flop synchroniser for the asynchronous interrupt lines
    always_ff @(posedge clk) begin
        if (rst) begin
            ip_meta_q <= {IRQ_NUM{1'b0}};
            ip_sync_q <= {IRQ_NUM{1'b0}};
        end else begin
            ip_meta_q <= cp0_ExcIP;
            ip_sync_q <= ip_meta_q;
        end
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) state_q <= ST_IDLE;
        else state_q <= state_d;
    end

    // FSM next state; software may enter or leave exception level through Status.EXL
    always_comb begin
        case (state_q)
            ST_IDLE: begin
                if (take_s) state_d = ST_REQ;
                else if (we_status_s && cp0_regWD[1] && !cp0_ExcEret) state_d = ST_INEXC;
                else state_d = ST_IDLE;
            end
            ST_REQ:  state_d = ST_INEXC;
            ST_INEXC: begin
                if (cp0_ExcEret) state_d = ST_IDLE;
                else if (we_status_s && !cp0_regWD[1]) state_d = ST_IDLE;
                else state_d = ST_INEXC;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // FSM outputs; a reset during REQ suppresses the strobe immediately
    always_comb begin
        if ((state_q == ST_REQ) && !rst) cp0_ExcRequest = 1'b1;
        else cp0_ExcRequest = 1'b0;
        cp0_EPC       = epc_q;
        cp0_ExcIsSync = (exccode_q != EXC_INT);
    end

    // Next values of the architectural registers; taking an exception outranks software writes
    always_comb begin
        if (we_count_s) count_d = cp0_regWD;
        else if (!dc_q) count_d = count_q + 32'd1;
        else count_d = count_q;

        if (we_compare_s) compare_d = cp0_regWD;
        else compare_d = compare_q;

        if (we_compare_s) ti_d = 1'b0;
        else if (!dc_q && (count_q == compare_q)) ti_d = 1'b1;
        else ti_d = ti_q;

        if (we_status_s) begin
            im_d = cp0_regWD[15:8];
            ie_d = cp0_regWD[0];
        end else begin
            im_d = im_q;
            ie_d = ie_q;
        end

        if (take_s) exl_d = 1'b1;
        else if (cp0_ExcEret) exl_d = 1'b0;
        else if (we_status_s) exl_d = cp0_regWD[1];
        else exl_d = exl_q;

        if (we_cause_s) begin
            sw_ip_d = cp0_regWD[9:8];
            dc_d    = cp0_regWD[27];
        end else begin
            sw_ip_d = sw_ip_q;
            dc_d    = dc_q;
        end
`ifdef SM_CPZ_VECTORED_IRQ_EN
        if (we_cause_s) iv_d = cp0_regWD[23];
        else iv_d = iv_q;
`else
        iv_d = 1'b0;
`endif

        if (take_s) begin
            epc_d = cp0_PC;
            if (cp0_ExcRI) exccode_d = EXC_RI;
            else if (cp0_ExcOv) exccode_d = EXC_OV;
            else exccode_d = EXC_INT;
        end else if (we_epc_s) begin
            epc_d     = cp0_regWD;
            exccode_d = exccode_q;
        end else begin
            epc_d     = epc_q;
            exccode_d = exccode_q;
        end

        if (we_ebase_s) ebase_d = cp0_regWD[29:12];
        else ebase_d = ebase_q;
    end

    // Architectural register bank
    always_ff @(posedge clk) begin
        if (rst) begin
            count_q   <= 32'd0;
            compare_q <= 32'd0;
            ti_q      <= 1'b0;
            im_q      <= 8'd0;
            exl_q     <= 1'b0;
            ie_q      <= 1'b0;
            sw_ip_q   <= 2'd0;
            dc_q      <= 1'b0;
            iv_q      <= 1'b0;
            exccode_q <= 5'd0;
            epc_q     <= 32'd0;
            ebase_q   <= EBASE_RST[29:12];
        end else begin
            count_q   <= count_d;
            compare_q <= compare_d;
            ti_q      <= ti_d;
            im_q      <= im_d;
            exl_q     <= exl_d;
            ie_q      <= ie_d;
            sw_ip_q   <= sw_ip_d;
            dc_q      <= dc_d;
            iv_q      <= iv_d;
            exccode_q <= exccode_d;
            epc_q     <= epc_d;
            ebase_q   <= ebase_d;
        end
    end

    // Register read mux
    always_comb begin
        case ({cp0_regNum, cp0_regSel})
            {5'd9,  3'd0}: cp0_regRD = count_q;
            {5'd11, 3'd0}: cp0_regRD = compare_q;
            {5'd12, 3'd0}: cp0_regRD = {16'd0, im_q, 6'd0, exl_q, ie_q};
            {5'd13, 3'd0}: cp0_regRD = {1'b0, ti_q, 2'd0, dc_q, 3'd0, iv_q, 7'd0,
                                        ip_s, 1'b0, exccode_q, 2'd0};
            {5'd14, 3'd0}: cp0_regRD = epc_q;
            {5'd15, 3'd1}: cp0_regRD = ebase_addr_s;
            default:       cp0_regRD = 32'd0;
        endcase
    end

endmodule

// File: tb/tb_sm_cpz_vic.sv
// Self-checking bench for sm_cpz_vic: strobes are matched against a scoreboard queue,
// register state is compared against bench-computed constants.
module tb_sm_cpz_vic;

    localparam int IRQ_NUM = 6;
`ifdef SM_CPZ_VECTORED_IRQ_EN
    localparam bit VEC = 1'b1;
`else
    localparam bit VEC = 1'b0;
`endif

    logic               clk = 1'b0;
    logic               rst;
    logic [31:0]        cp0_PC;
    logic [31:0]        cp0_EPC;
    logic [31:0]        cp0_ExcHandler;
    logic               cp0_ExcRequest;
    logic               cp0_ExcIsSync;
    logic               cp0_ExcEret;
    logic [4:0]         cp0_regNum;
    logic [2:0]         cp0_regSel;
    logic [31:0]        cp0_regRD;
    logic [31:0]        cp0_regWD;
    logic               cp0_regWE;
    logic [IRQ_NUM-1:0] cp0_ExcIP;
    logic               cp0_ExcRI;
    logic               cp0_ExcOv;

    sm_cpz_vic #(.IRQ_NUM(IRQ_NUM), .EBASE_RST(32'h0000_0000), .VEC_SPACING(32)) dut (
        .clk(clk), .rst(rst), .cp0_PC(cp0_PC), .cp0_EPC(cp0_EPC),
        .cp0_ExcHandler(cp0_ExcHandler), .cp0_ExcRequest(cp0_ExcRequest),
        .cp0_ExcIsSync(cp0_ExcIsSync), .cp0_ExcEret(cp0_ExcEret),
        .cp0_regNum(cp0_regNum), .cp0_regSel(cp0_regSel), .cp0_regRD(cp0_regRD),
        .cp0_regWD(cp0_regWD), .cp0_regWE(cp0_regWE), .cp0_ExcIP(cp0_ExcIP),
        .cp0_ExcRI(cp0_ExcRI), .cp0_ExcOv(cp0_ExcOv)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] handler;
        logic [31:0] epc;
        logic        is_sync;
    } exp_t;

    exp_t sb_q[$];
    int   pass_cnt   = 0;
    int   check_cnt  = 0;
    int   strobe_cnt = 0;

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        check_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got 32'h%08h expected 32'h%08h", tag, act, exp);
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic cp0_write(input logic [4:0] num, input logic [2:0] sel, input logic [31:0] data);
        cp0_regNum = num;
        cp0_regSel = sel;
        cp0_regWD  = data;
        cp0_regWE  = 1'b1;
        tick(1);
        cp0_regWE  = 1'b0;
    endtask

    task automatic cp0_read(input logic [4:0] num, input logic [2:0] sel, output logic [31:0] data);
        cp0_regNum = num;
        cp0_regSel = sel;
        #1;
        data = cp0_regRD;
    endtask

    task automatic expect_strobe(input logic [31:0] h, input logic [31:0] pc, input logic s);
        exp_t e;
        e.handler = h;
        e.epc     = pc;
        e.is_sync = s;
        sb_q.push_back(e);
    endtask

    task automatic wait_strobes(input int target, input int budget);
        for (int i = 0; i < budget && strobe_cnt < target; i++) tick(1);
        check_val("strobe_count", strobe_cnt, target);
    endtask

    task automatic eret();
        cp0_ExcEret = 1'b1;
        tick(1);
        cp0_ExcEret = 1'b0;
    endtask

    task automatic pulse_sync(input logic ri, input logic ov);
        cp0_ExcRI = ri;
        cp0_ExcOv = ov;
        tick(1);
        cp0_ExcRI = 1'b0;
        cp0_ExcOv = 1'b0;
    endtask

    // Strobe monitor: every strobe cycle must match the oldest expected entry
    initial begin
        forever begin
            @(negedge clk);
            if (cp0_ExcRequest === 1'b1) begin
                exp_t e;
                strobe_cnt++;
                check_val("sb_pending", 32'(sb_q.size() != 0), 32'd1);
                if (sb_q.size() != 0) begin
                    e = sb_q.pop_front();
                    check_val("handler", cp0_ExcHandler, e.handler);
                    check_val("epc_out", cp0_EPC, e.epc);
                    check_val("is_sync", {31'd0, cp0_ExcIsSync}, {31'd0, e.is_sync});
                end
            end
        end
    end

    initial begin
        logic [31:0] rd;
        logic [31:0] rd2;
        rst = 1'b1; cp0_PC = 32'h0040_0000; cp0_ExcEret = 1'b0;
        cp0_regNum = 5'd0; cp0_regSel = 3'd0; cp0_regWD = 32'd0; cp0_regWE = 1'b0;
        cp0_ExcIP = '0; cp0_ExcRI = 1'b0; cp0_ExcOv = 1'b0;

        // Reset state
        tick(3);
        cp0_read(5'd9, 3'd0, rd);  check_val("rst_count", rd, 32'd0);
        cp0_read(5'd12, 3'd0, rd); check_val("rst_status", rd, 32'd0);
        cp0_read(5'd13, 3'd0, rd); check_val("rst_cause", rd, 32'd0);
        tick(1);
        cp0_read(5'd11, 3'd0, rd); check_val("rst_compare", rd, 32'd0);
        cp0_read(5'd14, 3'd0, rd); check_val("rst_epc", rd, 32'd0);
        cp0_read(5'd15, 3'd1, rd); check_val("rst_ebase", rd, 32'd0);
        check_val("rst_request", {31'd0, cp0_ExcRequest}, 32'd0);
        rst = 1'b0;

        // Timer interrupt; first Compare write coincides with the 0==0 match
        cp0_PC = 32'h0040_1000;
        cp0_write(5'd11, 3'd0, 32'd10);
        cp0_read(5'd13, 3'd0, rd); check_val("ti_clear_wins0", rd, 32'd0);
        expect_strobe(32'h0000_0180, 32'h0040_1000, 1'b0);
        cp0_write(5'd12, 3'd0, 32'h0000_8001);
        wait_strobes(1, 40);
        cp0_read(5'd13, 3'd0, rd); check_val("t1_cause", rd & 32'h4000_007C, 32'h4000_0000);
        cp0_read(5'd12, 3'd0, rd); check_val("t1_status", rd, 32'h0000_8003);
        cp0_read(5'd14, 3'd0, rd); check_val("t1_epc", rd, 32'h0040_1000);
        cp0_write(5'd11, 3'd0, 32'hFFFF_0000);
        cp0_write(5'd12, 3'd0, 32'h0000_0002);
        eret();
        cp0_read(5'd12, 3'd0, rd); check_val("t1_eret_status", rd, 32'd0);
        tick(3);
        check_val("t1_no_extra", strobe_cnt, 1);

        // Hardware lines through the synchroniser, vectored when built in
        cp0_write(5'd13, 3'd0, 32'h0080_0000);
        cp0_read(5'd13, 3'd0, rd); check_val("t2_iv", rd & 32'h0080_0000, VEC ? 32'h0080_0000 : 32'd0);
        cp0_write(5'd12, 3'd0, 32'h0000_0C01);
        cp0_PC = 32'h0040_2000;
        expect_strobe(VEC ? 32'h0000_0260 : 32'h0000_0180, 32'h0040_2000, 1'b0);
        cp0_ExcIP = 6'b00_0011;
        tick(2);
        check_val("t2_early", {31'd0, cp0_ExcRequest}, 32'd0);
        tick(1);
        check_val("t2_strobe", {31'd0, cp0_ExcRequest}, 32'd1);
        wait_strobes(2, 5);
        cp0_read(5'd13, 3'd0, rd); check_val("t2_cause", rd & 32'h0000_FF7C, 32'h0000_0C00);
        cp0_write(5'd12, 3'd0, 32'h0000_0002);
        cp0_ExcIP = '0;
        cp0_write(5'd13, 3'd0, 32'd0);
        eret();
        tick(3);

        // Synchronous exceptions masked by EXL, then taken with RI > Ov priority
        cp0_write(5'd12, 3'd0, 32'h0000_0002);
        pulse_sync(1'b1, 1'b0);
        tick(2);
        check_val("t3_masked", strobe_cnt, 2);
        cp0_read(5'd13, 3'd0, rd); check_val("t3_code_kept", rd & 32'h0000_007C, 32'd0);
        eret();
        cp0_read(5'd12, 3'd0, rd); check_val("t3_status", rd, 32'd0);
        cp0_PC = 32'h0040_3000;
        expect_strobe(32'h0000_0180, 32'h0040_3000, 1'b1);
        pulse_sync(1'b1, 1'b0);
        wait_strobes(3, 5);
        cp0_read(5'd13, 3'd0, rd); check_val("t3_code_ri", rd & 32'h0000_007C, 32'h0000_0028);
        cp0_read(5'd12, 3'd0, rd); check_val("t3_exl", rd, 32'h0000_0002);
        eret();
        cp0_PC = 32'h0040_4000;
        expect_strobe(32'h0000_0180, 32'h0040_4000, 1'b1);
        pulse_sync(1'b0, 1'b1);
        wait_strobes(4, 5);
        cp0_read(5'd13, 3'd0, rd); check_val("t3_code_ov", rd & 32'h0000_007C, 32'h0000_0030);
        eret();
        cp0_PC = 32'h0040_5000;
        expect_strobe(32'h0000_0180, 32'h0040_5000, 1'b1);
        pulse_sync(1'b1, 1'b1);
        wait_strobes(5, 5);
        cp0_read(5'd13, 3'd0, rd); check_val("t3_code_prio", rd & 32'h0000_007C, 32'h0000_0028);
        eret();

        // Count wrap, match, clear-wins and DC freeze
        cp0_write(5'd9, 3'd0, 32'hFFFF_FFFE);
        cp0_read(5'd9, 3'd0, rd); check_val("t4_cnt0", rd, 32'hFFFF_FFFE);
        tick(1);
        cp0_read(5'd9, 3'd0, rd); check_val("t4_cnt1", rd, 32'hFFFF_FFFF);
        tick(1);
        cp0_read(5'd9, 3'd0, rd); check_val("t4_wrap", rd, 32'd0);
        cp0_write(5'd11, 3'd0, 32'd100);
        cp0_write(5'd9, 3'd0, 32'd100);
        cp0_write(5'd11, 3'd0, 32'd5000);
        cp0_read(5'd13, 3'd0, rd); check_val("t4_clear_wins", rd & 32'h4000_0000, 32'd0);
        cp0_write(5'd9, 3'd0, 32'd200);
        cp0_write(5'd11, 3'd0, 32'd203);
        tick(4);
        cp0_read(5'd13, 3'd0, rd); check_val("t4_ti_set", rd & 32'h4000_0000, 32'h4000_0000);
        tick(3);
        cp0_read(5'd13, 3'd0, rd); check_val("t4_ti_sticky", rd & 32'h4000_0000, 32'h4000_0000);
        cp0_write(5'd11, 3'd0, 32'hFFFF_0000);
        cp0_write(5'd13, 3'd0, 32'h0800_0000);
        cp0_read(5'd9, 3'd0, rd);
        tick(2);
        cp0_read(5'd9, 3'd0, rd2); check_val("t4_dc_freeze", rd2, rd);
        cp0_read(5'd13, 3'd0, rd); check_val("t4_dc_ti", rd & 32'h4800_0000, 32'h0800_0000);
        cp0_write(5'd13, 3'd0, 32'd0);

        // Reset asserted while in REQ aborts the exception
        cp0_PC = 32'h0040_6000;
        cp0_ExcRI = 1'b1;
        tick(1);
        cp0_ExcRI = 1'b0;
        rst = 1'b1;
        #1;
        check_val("t5_req_gated", {31'd0, cp0_ExcRequest}, 32'd0);
        check_val("t5_epc_cap", cp0_EPC, 32'h0040_6000);
        tick(1);
        rst = 1'b0;
        check_val("t5_epc_rst", cp0_EPC, 32'd0);
        cp0_read(5'd12, 3'd0, rd); check_val("t5_status", rd, 32'd0);
        tick(3);
        check_val("t5_no_strobe", strobe_cnt, 5);
        cp0_PC = 32'h0040_7000;
        expect_strobe(32'h0000_0180, 32'h0040_7000, 1'b1);
        pulse_sync(1'b1, 1'b0);
        wait_strobes(6, 5);
        eret();

        // EBase masking, IV handling and ERET with a pending interrupt
        cp0_write(5'd15, 3'd1, 32'hFFFF_FFFF);
        cp0_read(5'd15, 3'd1, rd); check_val("t6_ebase_mask", rd, 32'h3FFF_F000);
        cp0_write(5'd15, 3'd1, 32'h8000_5000);
        cp0_read(5'd15, 3'd1, rd); check_val("t6_ebase", rd, 32'h0000_5000);
        cp0_write(5'd13, 3'd0, 32'h0080_0100);
        cp0_read(5'd13, 3'd0, rd);
        check_val("t6_cause", rd & 32'h0080_0100, VEC ? 32'h0080_0100 : 32'h0000_0100);
        cp0_PC = 32'h0040_8000;
        expect_strobe(VEC ? 32'h0000_5200 : 32'h0000_5180, 32'h0040_8000, 1'b0);
        cp0_write(5'd12, 3'd0, 32'h0000_0101);
        wait_strobes(7, 6);
        cp0_PC = 32'h0040_9000;
        expect_strobe(VEC ? 32'h0000_5200 : 32'h0000_5180, 32'h0040_9000, 1'b0);
        eret();
        wait_strobes(8, 4);
        cp0_write(5'd12, 3'd0, 32'h0000_0002);
        eret();
        tick(3);
        check_val("sb_empty", sb_q.size(), 32'd0);
        check_val("final_strobes", strobe_cnt, 8);

        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

endmodule

// File: doc/sm_cpz_vic.md
SM_CPZ_VIC -- requirements
Module: sm_cpz_vic

Interface
REQ-001 Parameter IRQ_NUM, default 6, meaning number of hardware interrupt lines, legal 1..6, mapped to Cause.IP[2+IRQ_NUM-1:2].
REQ-002 Parameter EBASE_RST, default 32'h0000_0000, meaning EBase reset value; bits [11:0] SHALL be ignored.
REQ-003 Parameter VEC_SPACING, default 32, meaning byte distance between interrupt vectors; legal values are powers of two, 32..512.
REQ-004 The block SHALL use one clock and a synchronous active-high reset, with ports as follows.
REQ-005 clk  in  1  clock; all state updates on rising edge.
REQ-006 rst  in  1  synchronous active-high reset.
REQ-007 cp0_PC  in  32  next-PC address, captured as EPC.
REQ-008 cp0_EPC  out  32  EPC register.
REQ-009 cp0_ExcHandler  out  32  handler address for the current request.
REQ-010 cp0_ExcRequest  out  1  one-cycle exception request strobe.
REQ-011 cp0_ExcIsSync  out  1  latched exception is synchronous (ExcCode != 0).
REQ-012 cp0_ExcEret  in  1  ERET executed.
REQ-013 cp0_regNum, cp0_regSel  in  5, 3  register access select.
REQ-014 cp0_regRD  out  32  read data, combinational; unmapped registers read 0.
REQ-015 cp0_regWD, cp0_regWE  in  32, 1  write data and write enable.
REQ-016 cp0_ExcIP  in  IRQ_NUM  asynchronous level-sensitive hardware interrupts.
REQ-017 cp0_ExcRI, cp0_ExcOv  in  1, 1  reserved-instruction and overflow, single-cycle pulses.

Function
REQ-018 Register map (num/sel) SHALL be: Count 9/0, Compare 11/0, Status 12/0, Cause 13/0, EPC 14/0, EBase 15/1.
REQ-019 Status SHALL have fields IM[15:8], EXL[1] and IE[0]; other bits read 0.
REQ-020 Cause SHALL have fields TI[30], DC[27], IV[23], IP[15:8] and ExcCode[6:2]; IP[1:0], DC and IV are software-writable; the other bits are read-only.
REQ-021 EBase SHALL have writable bits [29:12]; bits [31:30] read 2'b00 and bits [11:0] read 0.
REQ-022 Each cp0_ExcIP line SHALL pass through a 2-flop synchroniser; IP[2+i] SHALL equal the synchronised level, giving 2 cycles of latency before IP is visible.
REQ-023 Count SHALL increment by 1 per cycle when DC=0 and wrap from 32'hFFFF_FFFF to 0; a write to Count wins over the increment.
REQ-024 TI SHALL set when Count==Compare and DC=0, stay sticky, and clear on a Compare write; a clear in the same cycle as a match wins; IP[7] SHALL be the OR of TI and the hardware line mapped there.
REQ-025 The interrupt condition SHALL be IE & ~EXL & |(IP & IM); the sync condition SHALL be (ExcRI | ExcOv) & ~EXL.
REQ-026 FSM states: IDLE, REQ, INEXC.
REQ-027 IDLE -> REQ when the sync or interrupt condition holds; in REQ, cp0_ExcRequest=1 for exactly one cycle; REQ -> INEXC unconditionally; INEXC -> IDLE on cp0_ExcEret.
REQ-028 On the IDLE->REQ edge, EXL is set to 1, EPC loads cp0_PC, and ExcCode loads RI 5'h0a, else Ov 5'h0c, else INT 5'h00 (priority RI > Ov > INT).
REQ-029 The vector index SHALL be the highest set bit of IP & IM (7 down to 0), latched on the IDLE->REQ edge.
REQ-030 cp0_ExcHandler SHALL be EBase+0x200+index*VEC_SPACING when IV=1 and ExcCode=INT; otherwise it SHALL be EBase+0x180.
REQ-031 An ERET in the same cycle as a pending condition SHALL clear EXL; the new request SHALL then be taken on the following cycle.
REQ-032 A Status write that sets EXL in IDLE SHALL move the FSM to INEXC with no strobe; a write that clears EXL in INEXC SHALL return it to IDLE.
REQ-033 A hardware request on the IDLE->REQ edge SHALL override a same-cycle Status write to EXL.

Reset
REQ-034 While rst=1 all registers SHALL be 0 except EBase=EBASE_RST; the FSM SHALL be IDLE, synchronisers cleared, and cp0_ExcRequest=0.
REQ-035 A reset asserted in REQ or INEXC SHALL abort the exception with no further strobe.

Configuration
REQ-036 With macro SM_CPZ_VECTORED_IRQ_EN defined, IV SHALL be writable and vectored addressing per REQ-030 SHALL apply.
REQ-037 Without SM_CPZ_VECTORED_IRQ_EN, IV SHALL read 0, IV writes SHALL be ignored, the index logic SHALL be omitted, and the handler SHALL always be EBase+0x180.

Verification
REQ-038 Compare=10, IE=1, IM[7]=1, DC=0 from reset -> TI=1 and one ExcRequest strobe; Handler=0x180; ExcCode=0; EPC=cp0_PC at the strobe edge.
REQ-039 IV=1, IM=8'h0C, ExcIP[1:0]=2'b11 -> strobe 3 cycles later; Handler=0x200+3*32=0x260.
REQ-040 ExcRI pulse while EXL=1 -> no strobe, ExcCode unchanged; after ERET, ExcRI pulse -> strobe, ExcCode=5'h0a, ExcIsSync=1.
REQ-041 Count written 32'hFFFF_FFFE -> reads 32'hFFFF_FFFF and then 0 on the next two cycles; a same-cycle Compare write and match -> TI=0.
REQ-042 rst asserted in the REQ state -> next cycle FSM is IDLE, EXL=0, EPC=0, no strobe.
REQ-043 Build without SM_CPZ_VECTORED_IRQ_EN, write IV=1 -> IV reads 0; an interrupt gives Handler=EBase+0x180.
